// File: rtl/mio_responder_if.sv
// Core-side memory/IO request/response bundle for mio_responder.
interface mio_responder_if;
  logic        CPU_MIO;
  logic        MemRW;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [31:0] Data_in;
  logic        MIO_ready;

  modport master (
    output CPU_MIO, MemRW, Addr_out, Data_out,
    input  Data_in, MIO_ready
  );

  modport slave (
    input  CPU_MIO, MemRW, Addr_out, Data_out,
    output Data_in, MIO_ready
  );
endinterface

// File: rtl/mio_responder.sv
// Memory/IO responder: word RAM, LED register, switch port and cycle counter
// behind a request/ready handshake with a fixed number of wait states.
module mio_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  mio_responder_if.slave     bus,
  input  logic [15:0]        sw,
  output logic [15:0]        led,
  output logic               busy
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [29:0] LED_WA = 30'h3C00_0000;
  localparam logic [29:0] SW_WA  = 30'h3C00_0001;
  localparam logic [29:0] CNT_WA = 30'h3C00_0002;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic        enter_done;

  logic [31:0] ram [DEPTH];

  logic [29:0] sel_addr;
  logic        sel_rd;
  logic [31:0] sel_val;
  logic        commit;
  logic        ram_we;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.Addr_out[1:0];

  // Handshake FSM: accept in IDLE, count wait states, one-cycle DONE.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.CPU_MIO) begin
          we_d    = bus.MemRW;
          addr_d  = bus.Addr_out[31:2];
          wdata_d = bus.Data_out;
          if (LATENCY == 0) begin
            state_d    = DONE;
            enter_done = 1'b1;
          end else begin
            state_d = WAIT;
            wait_d  = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        if (wait_q <= 4'd1) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read select and commit datapath. With zero latency DONE is entered straight
  // from IDLE, before the request is latched, so the live bus is decoded then.
  always_comb begin
    sel_addr = (state_q == IDLE) ? bus.Addr_out[31:2] : addr_q;
    sel_rd   = (state_q == IDLE) ? ~bus.MemRW : ~we_q;
    if (sel_addr[29:AW] == '0) sel_val = ram[sel_addr[AW-1:0]];
    else if (sel_addr == LED_WA) sel_val = {16'h0000, led_q};
    else if (sel_addr == SW_WA)  sel_val = {16'h0000, sw};
    else if (sel_addr == CNT_WA) sel_val = cnt_q;
    else                         sel_val = '0;

    rdata_d = rdata_q;
    if (enter_done)            rdata_d = sel_rd ? sel_val : '0;
    else if (state_q == DONE)  rdata_d = '0;

    commit = (state_q == DONE) && we_q;
    ram_we = commit && (addr_q[29:AW] == '0);
    led_d  = led_q;
    cnt_d  = cnt_q + 32'd1;
    if (commit && (addr_q == LED_WA)) led_d = wdata_q[15:0];
    if (commit && (addr_q == CNT_WA)) cnt_d = wdata_q;
  end

  // Control and peripheral registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data RAM write port; contents survive reset but reset blocks the commit.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[addr_q[AW-1:0]] <= wdata_q;
  end

  assign bus.Data_in   = rdata_q;
  assign bus.MIO_ready = (state_q == DONE);
  assign led           = led_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mio_responder.sv
// Randomized self-checking bench for mio_responder (LATENCY 2 and 0 instances).
module tb_mio_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;       // 0: LATENCY=2 instance, 1: LATENCY=0 instance
  logic        cpu_mio = 1'b0;
  logic        memrw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] sw_v = '0;
  logic [15:0] led2, led0;
  logic        busy2, busy0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state, indexed by instance.
  int          lat [2] = '{2, 0};
  logic [31:0] ram_m [2][64];
  bit          ram_v [2][64];
  logic [15:0] led_m [2];
  logic [31:0] cbase [2];
  int          ckb [2];

  mio_responder_if bus2 ();
  mio_responder_if bus0 ();

  assign bus2.CPU_MIO  = (sel == 1'b0) ? cpu_mio : 1'b0;
  assign bus2.MemRW    = memrw;
  assign bus2.Addr_out = addr;
  assign bus2.Data_out = wdata;
  assign bus0.CPU_MIO  = (sel == 1'b1) ? cpu_mio : 1'b0;
  assign bus0.MemRW    = memrw;
  assign bus0.Addr_out = addr;
  assign bus0.Data_out = wdata;

  wire        ready_o = sel ? bus0.MIO_ready : bus2.MIO_ready;
  wire [31:0] din_o   = sel ? bus0.Data_in   : bus2.Data_in;
  wire [15:0] led_o   = sel ? led0 : led2;
  wire        busy_o  = sel ? busy0 : busy2;

  mio_responder #(.DEPTH(64), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .sw(sw_v), .led(led2), .busy(busy2)
  );
  mio_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .sw(sw_v), .led(led0), .busy(busy0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (inst %0d, cycle %0d)", tag, act, exp, sel, cyc);
    end
  endtask

  function automatic logic [31:0] cnt_at(input int d, input int k);
    return cbase[d] + 32'(k - ckb[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      led_m[d] = '0;
      cbase[d] = '0;
      ckb[d]   = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One complete access on the selected instance; returns once back in IDLE.
  task automatic access(input bit rw, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    int d, n, e, idx;
    bit got, known;
    logic [29:0] wa;
    logic [31:0] exp;
    d = int'(sel);
    wa = a[31:2];
    cpu_mio = 1'b1; memrw = rw; addr = a; wdata = wd;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready_o) got = 1;
    end
    check("ready_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(lat[d] + 1));
    e = cyc;
    rd = din_o;
    if (!rw) begin
      known = 1;
      exp = '0;
      if (a < 32'd256) begin
        idx = int'(a[7:2]);
        known = ram_v[d][idx];
        exp = ram_m[d][idx];
      end else if (wa == 30'h3C00_0000) exp = {16'h0, led_m[d]};
      else if (wa == 30'h3C00_0001) exp = {16'h0, sw_v};
      else if (wa == 30'h3C00_0002) exp = cnt_at(d, e - 1);
      if (known) check("rdata", rd, exp);
    end else begin
      check("led_hold", 32'(led_o), 32'(led_m[d]));
    end
    cpu_mio = 1'b0;
    @(posedge clk); #1;
    if (rw) begin
      if (a < 32'd256) begin
        ram_m[d][a[7:2]] = wd;
        ram_v[d][a[7:2]] = 1;
      end else if (wa == 30'h3C00_0000) led_m[d] = wd[15:0];
      else if (wa == 30'h3C00_0002) begin
        cbase[d] = wd;
        ckb[d]   = cyc;
      end
    end
    check("din_clear", din_o, 32'd0);
    check("led", 32'(led_o), 32'(led_m[d]));
    check("busy_idle", 32'(busy_o), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1, 2: return (32'($urandom_range(0, 7)) << 2) | lo;
      3:       return 32'hF000_0000 | lo;
      4:       return 32'hF000_0004 | lo;
      5:       return 32'hF000_0008 | lo;
      6:       return 32'h0000_0100 | lo;
      default: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hF000_000C;
    endcase
  endfunction

  initial begin
    logic [31:0] rd, a;
    int pulses, consec, first, last, gaps_bad, quiet;
    bit prev;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) ram_v[d][i] = 0;

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();

    // Reset values on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_din", din_o, 32'd0);
      check("rst_led", 32'(led_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
    end
    sel = 1'b1;
    access(1'b0, 32'hF000_0008, '0, rd);
    sel = 1'b0;

    // RAM write then read-back at latency 2.
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd);
    access(1'b0, 32'h0000_0010, '0, rd);
    check("ram_deadbeef", rd, 32'hDEAD_BEEF);

    // LED write and switch read.
    access(1'b1, 32'hF000_0000, 32'h0001_A5A5, rd);
    check("led_a5a5", 32'(led_o), 32'h0000_A5A5);
    sw_v = 16'h1234;
    access(1'b0, 32'hF000_0004, '0, rd);
    check("sw_1234", rd, 32'h0000_1234);

    // Unmapped accesses complete but touch nothing.
    access(1'b1, 32'h0000_0000, 32'h0BAD_F00D, rd);
    access(1'b0, 32'h8000_0000, '0, rd);
    check("unmapped_rd", rd, 32'd0);
    access(1'b1, 32'h8000_0000, 32'hCAFE_F00D, rd);
    access(1'b0, 32'h0000_0000, '0, rd);
    check("unmapped_wr_ram", rd, 32'h0BAD_F00D);

    // Counter wrap on the zero-latency instance.
    sel = 1'b1;
    access(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, rd);
    idle(3);
    access(1'b0, 32'hF000_0008, '0, rd);
    check("cnt_wrap", rd, 32'h0000_0001);

    // Reset in WAIT aborts the write.
    sel = 1'b0;
    access(1'b1, 32'h0000_0004, 32'h1111_2222, rd);
    cpu_mio = 1'b1; memrw = 1'b1; addr = 32'h0000_0004; wdata = 32'h5555_5555;
    @(posedge clk); #1;
    check("wait_busy", 32'(busy_o), 32'd1);
    rst = 1'b1; cpu_mio = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready_o) quiet++;
      @(posedge clk); #1;
    end
    check("abort_no_ready", 32'(quiet), 32'd0);
    check("abort_led", 32'(led_o), 32'd0);
    access(1'b0, 32'h0000_0004, '0, rd);
    check("abort_old", rd, 32'h1111_2222);
    access(1'b0, 32'hF000_0008, '0, rd);

    // Back-to-back zero-latency reads with the request held high.
    sel = 1'b1;
    access(1'b1, 32'h0000_0014, 32'h7777_0001, rd);
    cpu_mio = 1'b1; memrw = 1'b0; addr = 32'h0000_0014;
    pulses = 0; consec = 0; first = -1; last = -1; gaps_bad = 0; prev = 0;
    for (int i = 1; i <= 12 && pulses < 4; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        pulses++;
        check("b2b_data", din_o, 32'h7777_0001);
        if (first < 0) first = i;
        else if (i - last != 2) gaps_bad++;
        last = i;
        if (prev) consec++;
        if (pulses == 4) cpu_mio = 1'b0;
      end
      prev = ready_o;
    end
    check("b2b_pulses", 32'(pulses), 32'd4);
    check("b2b_consec", 32'(consec), 32'd0);
    check("b2b_first", 32'(first), 32'd1);
    check("b2b_gaps", 32'(gaps_bad), 32'd0);
    @(posedge clk); #1;
    check("b2b_idle_ready", 32'(ready_o), 32'd0);

    // Random traffic on both instances against the model.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 8; i++) access(1'b1, 32'(i * 4), $urandom, rd);
    end
    for (int i = 0; i < 120; i++) begin
      sel = ($urandom_range(0, 1) != 0);
      sw_v = 16'($urandom);
      a = rand_addr();
      if ($urandom_range(0, 2) == 0) access(1'b1, a, $urandom, rd);
      else access(1'b0, a, '0, rd);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
